inst_fetch_unit: RTL and testbench

- Parametrised successor to the single-shot instruction processor.
- Sequentially assembles an INST_BYTES-wide little-endian instruction from the byte-wide RAM port, one byte per cycle.
- Tracks its own PC and presents each instruction to decode over a valid/ready handshake.
- Supports global pause (rdy_in), PC redirect/flush, and address wrap; sits between the RAM arbiter and decode.

---
 rtl/inst_fetch_unit.sv | 106 ++++++++++
 tb/tb_inst_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: assembles little-endian instructions one RAM byte per cycle and hands them to decode.
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous active-low reset
//   rdy_in          global ready, 0 pauses the unit
//   redirect_in     flush and restart fetch at redirect_pc_in
//   redirect_pc_in  new PC
//   mem_en_out      RAM read enable
//   mem_a_out       RAM byte address
//   mem_d_in        RAM read data, one cycle after the address
//   inst_out        assembled instruction
//   inst_pc_out     PC of inst_out
//   inst_valid_out  inst_out valid
//   inst_ready_in   decode accepts
module inst_fetch_unit #(
    parameter int          ADDR_WIDTH = 17,
    parameter int          INST_BYTES = 4,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    redirect_in,
    input  logic [31:0]             redirect_pc_in,
    output logic                    mem_en_out,
    output logic [ADDR_WIDTH-1:0]   mem_a_out,
    input  logic [7:0]              mem_d_in,
    output logic [8*INST_BYTES-1:0] inst_out,
    output logic [31:0]             inst_pc_out,
    output logic                    inst_valid_out,
    input  logic                    inst_ready_in
);
    localparam int IW = $clog2(INST_BYTES + 1);
    localparam logic [IW-1:0] NB      = IW'(INST_BYTES);
    localparam logic [IW-1:0] NB_LAST = IW'(INST_BYTES - 1);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t        state, state_nx;
    logic [31:0]   pc;
    logic [IW-1:0] issue_idx, cap_idx;
    logic          issued_q;
    logic          flush, handshake, issue, capture, last_cap;

    always_comb begin
        flush     = rdy_in & redirect_in;
        handshake = (state == HOLD) & inst_valid_out & inst_ready_in & rdy_in;
        issue     = (state == FETCH) & rdy_in & ~redirect_in & (issue_idx < NB);
        capture   = (state == FETCH) & rdy_in & ~redirect_in & issued_q;
        last_cap  = capture & (cap_idx == NB_LAST);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state <= FETCH;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = (flush || handshake) ? FETCH : last_cap ? HOLD : state;
    end

    // Reset gates the combinational RAM port so it reads 0 while rst_in is low.
    always_comb begin
        mem_en_out = rst_in & issue;
        mem_a_out  = rst_in ? ADDR_WIDTH'(pc + 32'(issue_idx)) : '0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc             <= RESET_PC;
            issue_idx      <= '0;
            cap_idx        <= '0;
            issued_q       <= 1'b0;
            inst_out       <= '0;
            inst_pc_out    <= '0;
            inst_valid_out <= 1'b0;
        end else if (rdy_in) begin
            issued_q <= issue;
            if (flush || handshake) begin
                // Redirect wins over pc+INST_BYTES; a same-cycle handshake still completes.
                issue_idx      <= '0;
                cap_idx        <= '0;
                inst_valid_out <= 1'b0;
                pc             <= flush ? redirect_pc_in : pc + 32'(INST_BYTES);
            end else begin
                if (issue)
                    issue_idx <= issue_idx + 1'b1;
                if (capture)
                    cap_idx <= cap_idx + 1'b1;
                for (int k = 0; k < INST_BYTES; k++)
                    if (capture && cap_idx == IW'(k))
                        inst_out[8*k +: 8] <= mem_d_in;
                if (last_cap) begin
                    inst_valid_out <= 1'b1;
                    inst_pc_out    <= pc;
                end
            end
        end else begin
            // The byte whose data lands during a pause is lost; rewind so it is re-issued.
            issued_q  <= 1'b0;
            issue_idx <= cap_idx;
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scoreboard bench for inst_fetch_unit with a registered byte RAM model.
module tb_inst_fetch_unit;
    localparam int AW = 17;
    localparam int NB = 4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic            clk_in = 1'b0;
    logic            rst_in, rdy_in, redirect_in, inst_ready_in;
    logic [31:0]     redirect_pc_in;
    logic            mem_en_out;
    logic [AW-1:0]   mem_a_out;
    logic [7:0]      mem_d_in;
    logic [8*NB-1:0] inst_out;
    logic [31:0]     inst_pc_out;
    logic            inst_valid_out;

    logic [7:0]  ram [0:(1<<AW)-1];
    exp_t        sb[$];
    logic [31:0] addr_log[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_cnt = 0;
    int          cyc, acc0;

    inst_fetch_unit #(.ADDR_WIDTH(AW), .INST_BYTES(NB), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
        .mem_en_out(mem_en_out), .mem_a_out(mem_a_out), .mem_d_in(mem_d_in),
        .inst_out(inst_out), .inst_pc_out(inst_pc_out),
        .inst_valid_out(inst_valid_out), .inst_ready_in(inst_ready_in)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) mem_d_in <= ram[mem_a_out];
    always @(posedge clk_in) if (rst_in && inst_valid_out && inst_ready_in && rdy_in) acc_cnt <= acc_cnt + 1;
    always @(negedge clk_in) if (mem_en_out) addr_log.push_back(32'(mem_a_out));

    function automatic logic [31:0] model_inst(input logic [31:0] pc);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = ram[AW'(pc + 32'(k))];
        return r;
    endfunction

    task automatic push(input logic [31:0] pc);
        exp_t x;
        x.inst = model_inst(pc);
        x.pc   = pc;
        sb.push_back(x);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input int idx, input logic [31:0] exp);
        chk(tag, (idx < addr_log.size()) ? 64'(addr_log[idx]) : 64'hDEAD_0000, 64'(exp));
    endtask

    task automatic wait_valid(output int c);
        exp_t x;
        c = -1;
        for (int i = 0; i < 40 && c < 0; i++) begin
            @(negedge clk_in);
            if (inst_valid_out) c = i;
        end
        if (c < 0)
            chk("valid_timeout", 64'(inst_valid_out), 64'd1);
        else if (sb.size() == 0)
            chk("unexpected_valid", 64'(inst_valid_out), 64'd0);
        else begin
            x = sb.pop_front();
            chk("sb_inst", 64'(inst_out), 64'(x.inst));
            chk("sb_pc", 64'(inst_pc_out), 64'(x.pc));
        end
    endtask

    task automatic accept();
        inst_ready_in = 1'b1;
        @(posedge clk_in);
        #1 inst_ready_in = 1'b0;
        addr_log.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 64'(inst_valid_out), 64'd0);
        chk({tag, "_mem_en"}, 64'(mem_en_out), 64'd0);
        chk({tag, "_mem_a"}, 64'(mem_a_out), 64'd0);
        chk({tag, "_inst"}, 64'(inst_out), 64'd0);
        chk({tag, "_pc"}, 64'(inst_pc_out), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[AW'(i)] = 8'((i * 37 + 11) ^ (i >> 7));
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
        rst_in = 1'b0; rdy_in = 1'b1; redirect_in = 1'b0; redirect_pc_in = '0; inst_ready_in = 1'b0;
        #2 chk_zero("reset");

        // basic fetch from RESET_PC
        push(32'h0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        wait_valid(cyc);
        chk("basic_latency", 64'(cyc), 64'd5);
        chk("basic_inst", 64'(inst_out), 64'h0010_0513);
        for (int k = 0; k < 4; k++) chk_addr("basic_addr", k, 32'(k));
        chk("basic_addr_cnt", 64'(addr_log.size()), 64'd4);

        // backpressure: held stable, no RAM traffic
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            chk("bp_valid", 64'(inst_valid_out), 64'd1);
            chk("bp_mem_en", 64'(mem_en_out), 64'd0);
            chk("bp_inst", 64'(inst_out), 64'h0010_0513);
        end
        acc0 = acc_cnt;
        push(32'h4);
        accept();
        wait_valid(cyc);
        chk("bp_one_accept", 64'(acc_cnt - acc0), 64'd1);
        chk("next_latency", 64'(cyc), 64'd5);
        chk_addr("next_addr0", 0, 32'h4);

        // pause right after byte 1 is issued
        push(32'h8);
        accept();
        @(posedge clk_in); #1;
        @(posedge clk_in); #1 rdy_in = 1'b0;
        @(negedge clk_in);
        chk("pause_mem_en", 64'(mem_en_out), 64'd0);
        repeat (3) @(posedge clk_in);
        #1 rdy_in = 1'b1;
        wait_valid(cyc);
        chk_addr("pause_addr0", 0, 32'h8);
        chk_addr("pause_addr1", 1, 32'h9);
        chk_addr("pause_reissue", 2, 32'h9);
        chk_addr("pause_addr3", 3, 32'hA);
        chk_addr("pause_addr4", 4, 32'hB);
        chk("pause_addr_cnt", 64'(addr_log.size()), 64'd5);

        // redirect mid-fetch, old instruction at 0xC never appears
        push(32'h100);
        accept();
        @(posedge clk_in); #1;
        @(posedge clk_in); #1 redirect_in = 1'b1; redirect_pc_in = 32'h100;
        @(negedge clk_in);
        chk("redir_mem_en", 64'(mem_en_out), 64'd0);
        @(posedge clk_in);
        #1 redirect_in = 1'b0;
        addr_log.delete();
        wait_valid(cyc);
        for (int k = 0; k < 4; k++) chk_addr("redir_addr", k, 32'h100 + 32'(k));

        // redirect together with handshake
        acc0 = acc_cnt;
        push(32'h40);
        inst_ready_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 32'h40;
        @(posedge clk_in);
        #1 inst_ready_in = 1'b0; redirect_in = 1'b0;
        wait_valid(cyc);
        chk("redir_hs_accept", 64'(acc_cnt - acc0), 64'd1);

        // address wrap, redirect issued from HOLD without a handshake
        acc0 = acc_cnt;
        push(32'h1FFFE);
        redirect_in = 1'b1; redirect_pc_in = 32'h1FFFE;
        @(posedge clk_in);
        #1 redirect_in = 1'b0;
        addr_log.delete();
        wait_valid(cyc);
        chk("wrap_no_accept", 64'(acc_cnt - acc0), 64'd0);
        for (int k = 0; k < 4; k++) chk_addr("wrap_addr", k, (32'h1FFFE + 32'(k)) & 32'h1FFFF);
        push(32'h20002);
        accept();
        wait_valid(cyc);
        for (int k = 0; k < 4; k++) chk_addr("wrap_next_addr", k, 32'h2 + 32'(k));

        // asynchronous reset mid-fetch
        accept();
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        #1 chk_zero("async_rst");
        push(32'h0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        addr_log.delete();
        wait_valid(cyc);
        chk("rst_latency", 64'(cyc), 64'd5);
        chk("rst_inst", 64'(inst_out), 64'h0010_0513);
        for (int k = 0; k < 4; k++) chk_addr("rst_addr", k, 32'(k));

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
